// File: rtl/regfile_dump.sv
`default_nettype none
// ============================================================================
// Module      : regfile_dump
// Description : Walks a register file through a spare read port and streams
//               each register value out over a valid/ready interface.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_dump #(
    parameter int NREGS = 32,
    parameter int XLEN  = 32,
    parameter int AW    = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [AW-1:0]   rd_addr,
    input  logic [XLEN-1:0] rd_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic [AW-1:0]   out_idx,
    output logic            out_last,
    output logic            busy,
    output logic            done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SEND  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [AW-1:0] C_LAST_IDX = AW'(NREGS - 1);
    localparam logic [AW-1:0] C_ONE      = AW'(1);

    state_t r_state;
    state_t w_next_state;
    logic   w_beat_taken;

    assign w_beat_taken = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        busy         = 1'b1;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next_state = S_FETCH;
                end
            end
            S_FETCH: begin
                w_next_state = S_SEND;
            end
            S_SEND: begin
                if (w_beat_taken) begin
                    w_next_state = out_last ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // The read data is sampled at the FETCH edge; later write-backs to an
    // already fetched register are intentionally not reflected.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        rd_addr <= '0;
                    end
                end
                S_FETCH: begin
                    out_data  <= rd_data;
                    out_idx   <= rd_addr;
                    out_last  <= (rd_addr == C_LAST_IDX);
                    out_valid <= 1'b1;
                end
                S_SEND: begin
                    if (w_beat_taken) begin
                        out_valid <= 1'b0;
                        if (!out_last) begin
                            rd_addr <= rd_addr + C_ONE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_dump
// Description : Scoreboard bench for regfile_dump with a behavioural regfile.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_dump;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [4:0]  out_idx;
    logic        out_last;
    logic        busy;
    logic        done;

    regfile_dump #(.NREGS(32), .XLEN(32), .AW(5)) dut (
        .clk(clk), .rst(rst), .start(start),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [32];
    assign rd_data = mem[rd_addr];

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  idx;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int beat_cnt = 0;
    bit rand_ready = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: pops on every beat that will be accepted at the coming edge.
    bit          stall_prev = 1'b0;
    logic [31:0] hold_data;
    logic [4:0]  hold_idx;
    logic        hold_last;
    initial forever begin
        @(negedge clk);
        if (done && !rst) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (stall_prev && !rst) begin
            chk("stall_data", out_data, hold_data);
            chk("stall_idx", 32'(out_idx), 32'(hold_idx));
            chk("stall_last", 32'(out_last), 32'(hold_last));
        end
        stall_prev = out_valid && !out_ready && !rst;
        hold_data  = out_data;
        hold_idx   = out_idx;
        hold_last  = out_last;
        if (out_valid && out_ready && !rst) begin
            beat_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got idx %0d expected none", out_idx);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                chk("beat_data", out_data, e.data);
                chk("beat_idx", 32'(out_idx), 32'(e.idx));
                chk("beat_last", 32'(out_last), 32'(e.last));
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    endtask

    // Issues a one-cycle start pulse; returns the cycle number of the sampling edge.
    task automatic pulse_start(output int c0);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        c0 = cyc;
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        int d0 = done_cnt;
        while (done_cnt == d0 && n < bound) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt == d0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within %0d cycles", bound);
        end
    endtask

    task automatic wait_idx(input int k);
        int n = 0;
        while (!(out_valid && out_idx == 5'(k)) && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 400) begin
            checks++;
            errors++;
            $display("FAIL idx_timeout: got no beat expected idx %0d", k);
        end
    endtask

    task automatic push_dump(input logic [31:0] v5, input logic [31:0] v12, input logic [31:0] v31);
        for (int i = 0; i < 32; i++) begin
            beat_t b;
            b.data = (i == 5) ? v5 : (i == 12) ? v12 : (i == 31) ? v31 : 32'h0;
            b.idx  = 5'(i);
            b.last = (i == 31);
            exp_q.push_back(b);
        end
    endtask

    task automatic end_of_dump(input string name, input int d0, input int b0);
        repeat (3) @(posedge clk);
        #1;
        chk({name, "_done_cnt"}, 32'(done_cnt - d0), 32'd1);
        chk({name, "_beats"}, 32'(beat_cnt - b0), 32'd32);
        chk({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        chk({name, "_busy_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int c0;
        int d0;
        int b0;
        clear_mem();

        // Reset with start held high
        rst = 1'b1;
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_idx", 32'(out_idx), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_addr", 32'(rd_addr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("post_rst_valid", 32'(out_valid), 32'd0);
            chk("post_rst_busy", 32'(busy), 32'd0);
        end

        // Full dump, out_ready held high
        mem[5]  = 32'hDEADBEEF;
        mem[31] = 32'h00002004;
        push_dump(32'hDEADBEEF, 32'h0, 32'h00002004);
        d0 = done_cnt;
        b0 = beat_cnt;
        pulse_start(c0);
        chk("busy_after_start", 32'(busy), 32'd1);
        wait_done(200);
        chk("done_latency", 32'(done_cyc - c0), 32'd64);
        end_of_dump("full", d0, b0);

        // Random backpressure
        rand_ready = 1'b1;
        push_dump(32'hDEADBEEF, 32'h0, 32'h00002004);
        d0 = done_cnt;
        b0 = beat_cnt;
        pulse_start(c0);
        wait_done(1000);
        rand_ready = 1'b0;
        end_of_dump("bp", d0, b0);

        // start pulses while busy are ignored
        push_dump(32'hDEADBEEF, 32'h0, 32'h00002004);
        d0 = done_cnt;
        b0 = beat_cnt;
        pulse_start(c0);
        wait_idx(3);
        pulse_start(c0);
        wait_idx(20);
        pulse_start(c0);
        wait_done(200);
        end_of_dump("restart", d0, b0);

        // Reset mid-dump at idx 10
        push_dump(32'hDEADBEEF, 32'h0, 32'h00002004);
        d0 = done_cnt;
        pulse_start(c0);
        wait_idx(10);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        push_dump(32'hDEADBEEF, 32'h0, 32'h00002004);
        d0 = done_cnt;
        b0 = beat_cnt;
        pulse_start(c0);
        wait_done(200);
        end_of_dump("fresh", d0, b0);

        // Write-back racing the dump: x3 already fetched, x12 not yet
        clear_mem();
        push_dump(32'h0, 32'h12345678, 32'h0);
        d0 = done_cnt;
        b0 = beat_cnt;
        pulse_start(c0);
        wait_idx(4);
        mem[12] = 32'h12345678;
        mem[3]  = 32'hCAFEF00D;
        wait_done(200);
        end_of_dump("wb", d0, b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
